// File: rtl/miner_pkg.sv
// miner_pkg
//   Shared definitions for the miner datapath blocks.
//   - NONCE_W              : width of a nonce word.
//   - EXHAUST_WORD_DEFAULT : word sent to the host to ask for new work.
//   - state_t              : result-queue FSM encoding (IDLE=0, LAUNCH=1,
//                            WAIT_ACCEPT=2, WAIT_DONE=3).
package miner_pkg;

   localparam int NONCE_W = 32;

   localparam logic [NONCE_W-1:0] EXHAUST_WORD_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      LAUNCH      = 2'd1,
      WAIT_ACCEPT = 2'd2,
      WAIT_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/nonce_fifo.sv
// nonce_fifo
//   Synchronous circular FIFO of NONCE_W-bit words, 2^DEPTH_LOG2 entries.
//   Pointers carry one extra bit so full and empty are distinguishable.
//   A push while full and a pop while empty are ignored.
// Ports:
//   clk      in   clock (posedge)
//   reset    in   asynchronous active-high reset
//   wr_en    in   push wr_data when not full
//   wr_data  in   NONCE_W word to push
//   rd_en    in   pop the head when not empty
//   rd_data  out  current head word (valid when !empty)
//   full     out  2^DEPTH_LOG2 entries held
//   empty    out  no entries held
//   fill     out  registered occupancy after the current edge
module nonce_fifo
   import miner_pkg::*;
#(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [NONCE_W-1:0]   wr_data,
   input  logic                 rd_en,
   output logic [NONCE_W-1:0]   rd_data,
   output logic                 full,
   output logic                 empty,
   output logic [DEPTH_LOG2:0]  fill
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [NONCE_W-1:0]  mem [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr;
   logic [DEPTH_LOG2:0] rd_ptr;
   logic [DEPTH_LOG2:0] used;
   logic                wr_do;
   logic                rd_do;

   assign used    = wr_ptr - rd_ptr;
   assign full    = (used == (DEPTH_LOG2+1)'(DEPTH));
   assign empty   = (wr_ptr == rd_ptr);
   assign wr_do   = wr_en & ~full;
   assign rd_do   = rd_en & ~empty;
   assign rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (wr_do) wr_ptr <= wr_ptr + 1'b1;
         if (rd_do) rd_ptr <= rd_ptr + 1'b1;
         // Simultaneous push and pop leave occupancy unchanged.
         case ({wr_do, rd_do})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (wr_do) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
   end

endmodule

// File: rtl/nonce_result_queue.sv
// nonce_result_queue
//   Queues golden nonces (and a coalesced "work exhausted" marker) for the
//   UART transmitter. Nonces always go first; the marker only goes out when
//   the FIFO is empty.
//   Handshake with serial_transmit: tx_send is a one-cycle strobe issued only
//   while tx_busy=0; the transmitter accepts by raising tx_busy, and the word
//   is done when tx_busy falls. tx_word is held from the strobe until then.
//   If tx_busy does not rise within ACK_TIMEOUT cycles the word is abandoned.
// Ports:
//   hash_clk     in   clock (posedge)
//   reset        in   asynchronous active-high reset
//   found        in   one-cycle pulse, found_nonce is a golden nonce
//   found_nonce  in   nonce to enqueue
//   exhausted    in   level or pulse requesting new work
//   tx_busy      in   busy from serial_transmit
//   tx_send      out  send strobe to serial_transmit
//   tx_word      out  word to serial_transmit
//   fill         out  FIFO occupancy
//   overflow     out  sticky, a found arrived while the FIFO was full
//   sent_count   out  (NONCE_QUEUE_STATS_EN) nonces launched
//   drop_count   out  (NONCE_QUEUE_STATS_EN) overflows + timeouts, saturating
//   state        out  FSM state for observation
// Build option: define NONCE_QUEUE_STATS_EN to add the statistics counters.
module nonce_result_queue
   import miner_pkg::*;
#(
   parameter int                 DEPTH_LOG2   = 3,
   parameter int                 ACK_TIMEOUT  = 16,
   parameter logic [NONCE_W-1:0] EXHAUST_WORD = EXHAUST_WORD_DEFAULT
) (
   input  logic                 hash_clk,
   input  logic                 reset,
   input  logic                 found,
   input  logic [NONCE_W-1:0]   found_nonce,
   input  logic                 exhausted,
   input  logic                 tx_busy,
   output logic                 tx_send,
   output logic [NONCE_W-1:0]   tx_word,
   output logic [DEPTH_LOG2:0]  fill,
   output logic                 overflow,
`ifdef NONCE_QUEUE_STATS_EN
   output logic [31:0]          sent_count,
   output logic [15:0]          drop_count,
`endif
   output state_t               state
);

   state_t             state_q;
   state_t             state_d;
   logic               full;
   logic               empty;
   logic [NONCE_W-1:0] head;
   logic               rd_en;
   logic               launch_nonce;    // word in flight came from the FIFO
   logic               exhaust_pending;
   logic               exhaust_served;  // marker sent for the current request
   logic [7:0]         timer;
   logic               ovf_evt;
   logic               timeout_evt;
   logic               marker_launch;

   nonce_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .clk     (hash_clk),
      .reset   (reset),
      .wr_en   (found),
      .wr_data (found_nonce),
      .rd_en   (rd_en),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .fill    (fill)
   );

   // Strobe decoded from the state register so reset removes it immediately.
   assign tx_send       = (state_q == LAUNCH);
   assign rd_en         = tx_send & launch_nonce;
   assign marker_launch = tx_send & ~launch_nonce;
   assign ovf_evt       = found & full;
   assign timeout_evt   = (state_q == WAIT_ACCEPT) & ~tx_busy & (timer <= 8'd1);
   assign state         = state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:        if (!tx_busy && (!empty || exhaust_pending)) state_d = LAUNCH;
         LAUNCH:      state_d = WAIT_ACCEPT;
         WAIT_ACCEPT: begin
            if (tx_busy)          state_d = WAIT_DONE;
            else if (timeout_evt) state_d = IDLE;
         end
         WAIT_DONE:   if (!tx_busy) state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   always_ff @(posedge hash_clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         tx_word         <= '0;
         launch_nonce    <= 1'b0;
         exhaust_pending <= 1'b0;
         exhaust_served  <= 1'b0;
         timer           <= '0;
         overflow        <= 1'b0;
      end else begin
         state_q <= state_d;

         if (state_q == IDLE && state_d == LAUNCH) begin
            tx_word      <= empty ? EXHAUST_WORD : head;
            launch_nonce <= ~empty;
         end

         if (state_q == LAUNCH)
            timer <= 8'(ACK_TIMEOUT);
         else if (state_q == WAIT_ACCEPT && !tx_busy)
            timer <= timer - 8'd1;

         // A level held across the marker's launch must not re-arm it; the
         // request is considered new again once exhausted has dropped.
         if (marker_launch) begin
            exhaust_pending <= 1'b0;
            exhaust_served  <= 1'b1;
         end else begin
            if (exhausted && !exhaust_served) exhaust_pending <= 1'b1;
            if (!exhausted)                   exhaust_served  <= 1'b0;
         end

         if (ovf_evt) overflow <= 1'b1;
      end
   end

`ifdef NONCE_QUEUE_STATS_EN
   logic [16:0] drop_sum;

   assign drop_sum = {1'b0, drop_count} + 17'(ovf_evt) + 17'(timeout_evt);

   always_ff @(posedge hash_clk or posedge reset) begin
      if (reset) begin
         sent_count <= '0;
         drop_count <= '0;
      end else begin
         if (rd_en) sent_count <= sent_count + 32'd1;
         drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end
`endif

endmodule
